// File: rtl/uart_pkg.sv
// Shared UART receive definitions. The cipher stage imports the same
// XON/XOFF codes from here.
package uart_pkg;

  localparam int OSR = 16;
  localparam logic [7:0] CTRL_XOFF = 8'h13;
  localparam logic [7:0] CTRL_XON  = 8'h11;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  function automatic logic is_flow_ctrl(input logic [7:0] b);
    return (b == CTRL_XOFF) || (b == CTRL_XON);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick divider. The counter restarts from 0 on
// clr so that tick phase is aligned to the detected start edge.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_baud_tick: DIV must be at least 2");
    end
  endgenerate

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (cnt == W'(DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/uart_rx_flow.sv
// UART 8N1 receiver with XON/XOFF detection and a sticky tx_paused flag.
// state | meaning: IDLE wait edge | START check mid start | DATA shift 8 bits | STOP check stop bit
module uart_rx_flow
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       is_control_char,
  output logic       framing_err,
  output logic       tx_paused
);
  localparam int DIV = CLK_FREQ / (BAUD * OSR);

  logic           sync1, sync2, rx_prev;
  logic           start_edge, edge_q, start_hit;
  logic           tick;
  uart_rx_state_t state;
  logic [3:0]     tick_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign start_edge = rx_prev & ~sync2;
  // edge_q keeps an edge that landed on the STOP sample cycle alive for IDLE
  assign start_hit  = (state == IDLE) && (start_edge || edge_q);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_hit),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      edge_q          <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      is_control_char <= 1'b0;
      framing_err     <= 1'b0;
      tx_paused       <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      edge_q      <= start_edge;
      case (state)
        IDLE: begin
          if (start_hit) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'(OSR / 2 - 1)) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= sync2 ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'(OSR - 1)) begin
              tick_cnt <= '0;
              shreg    <= {sync2, shreg[7:1]};
              if (bit_idx == 3'd7)
                state <= STOP;
              else
                bit_idx <= bit_idx + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'(OSR - 1)) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (sync2) begin
                rx_data         <= shreg;
                rx_valid        <= 1'b1;
                is_control_char <= is_flow_ctrl(shreg);
                if (shreg == CTRL_XOFF)
                  tx_paused <= 1'b1;
                else if (shreg == CTRL_XON)
                  tx_paused <= 1'b0;
              end else begin
                framing_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_flow.sv
// Self-checking bench for uart_rx_flow: table-driven frames plus hand-written
// glitch, back-to-back and mid-frame reset sequences, checked by a scoreboard.
module tb_uart_rx_flow;
  import uart_pkg::*;

  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, is_control_char, framing_err, tx_paused;

  int checks = 0;
  int errors = 0;
  int good_expected = 0;
  int good_seen = 0;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       ctrl;
    logic       paused;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_ferr;
    logic [7:0] exp_data;
    logic       exp_ctrl;
    logic       exp_paused;
  } vec_t;

  ev_t exp_q[$];
  logic prev_valid = 1'b0;

  uart_rx_flow #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .is_control_char (is_control_char),
    .framing_err     (framing_err),
    .tx_paused       (tx_paused)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_valid) begin
        good_seen++;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL pulse_width: rx_valid high on consecutive cycles, required one cycle");
        end
      end
      if (rx_valid || framing_err) begin
        checks++;
        if (rx_valid && framing_err) begin
          errors++;
          $display("FAIL exclusive: rx_valid and framing_err both high, required only one");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%0b ferr=%0b data=%02h, required no event",
                   rx_valid, framing_err, rx_data);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          checks++;
          if (framing_err !== e.ferr || rx_data !== e.data ||
              is_control_char !== e.ctrl || tx_paused !== e.paused) begin
            errors++;
            $display("FAIL event: got ferr=%0b data=%02h ctrl=%0b paused=%0b, required ferr=%0b data=%02h ctrl=%0b paused=%0b",
                     framing_err, rx_data, is_control_char, tx_paused,
                     e.ferr, e.data, e.ctrl, e.paused);
          end
        end
      end
      prev_valid <= rx_valid;
    end
  end

  task automatic hold_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
    hold_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold_bit(d[i], BIT_CLK);
    hold_bit(stop, BIT_CLK);
    if (gap_bits > 0) hold_bit(1'b1, gap_bits * BIT_CLK);
  endtask

  task automatic push_ev(input logic ferr, input logic [7:0] d, input logic c, input logic p);
    ev_t e;
    e.ferr = ferr; e.data = d; e.ctrl = c; e.paused = p;
    exp_q.push_back(e);
    if (!ferr) good_expected++;
  endtask

  task automatic expect_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events not produced, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h13, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1};
    vecs[2] = '{8'h61, 1'b1, 1'b0, 8'h61, 1'b0, 1'b1};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[5] = '{8'hAA, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0};
    vecs[6] = '{8'h13, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1};
    vecs[7] = '{8'h13, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %02h, required 00", rx_data);
    end
    check_bit("reset_rx_valid", rx_valid, 1'b0);
    check_bit("reset_ctrl", is_control_char, 1'b0);
    check_bit("reset_ferr", framing_err, 1'b0);
    check_bit("reset_paused", tx_paused, 1'b0);
    repeat (50) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      push_ev(vecs[i].exp_ferr, vecs[i].exp_data, vecs[i].exp_ctrl, vecs[i].exp_paused);
      send_frame(vecs[i].d, vecs[i].stop, 1);
      expect_drained($sformatf("vec%0d_drained", i));
    end

    // short low glitch on an idle line
    hold_bit(1'b0, 50);
    hold_bit(1'b1, 400);
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL glitch_idle: state %0d, required IDLE", dut.state);
    end
    expect_drained("glitch_no_event");

    push_ev(1'b0, 8'h00, 1'b0, 1'b1);
    push_ev(1'b0, 8'hFF, 1'b0, 1'b1);
    push_ev(1'b0, 8'h7A, 1'b0, 1'b1);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h7A, 1'b1, 1);
    expect_drained("b2b_drained");

    // abort a frame in bit 4 with tx_paused=1 and rx_data=7A
    hold_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold_bit(i[0], BIT_CLK);
    hold_bit(1'b0, BIT_CLK / 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_rx_data: got %02h, required 00", rx_data);
    end
    check_bit("rst_rx_valid", rx_valid, 1'b0);
    check_bit("rst_ctrl", is_control_char, 1'b0);
    check_bit("rst_ferr", framing_err, 1'b0);
    check_bit("rst_paused", tx_paused, 1'b0);
    hold_bit(1'b1, 2000);
    expect_drained("rst_no_event");

    push_ev(1'b0, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1);
    expect_drained("after_rst_drained");

    checks++;
    if (good_seen != good_expected) begin
      errors++;
      $display("FAIL valid_count: got %0d, required %0d", good_seen, good_expected);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete within time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_flow.md
# uart_rx_flow

UART 8N1 receiver with XON/XOFF detection, directly upstream of the Caesar cipher stage. It oversamples the serial line at 16x and deserialises each frame. It delivers each good byte as a one-cycle valid pulse, together with a control-character flag that the cipher stage uses to force 0x00 output for Ctrl+S/Ctrl+Q. It also maintains a sticky flow-control pause state for the transmit side.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, Hz.
- BAUD, 115_200: line rate, baud.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  8  last correctly framed byte; holds until the next good byte.
- rx_valid  out  1  one-cycle pulse; rx_data/is_control_char updated this cycle.
- is_control_char  out  1  rx_data is 0x13 (XOFF) or 0x11 (XON); held with rx_data.
- framing_err  out  1  one-cycle pulse on bad stop bit.
- tx_paused  out  1  1 after XOFF, 0 after XON; sticky.

## Operation
- rx passes through a 2-FF synchroniser; both flops reset to 1.
- Oversample tick: divider DIV = CLK_FREQ/(BAUD*16), truncated.
  - Elaboration error if DIV < 2.
  - Counter 0..DIV-1; tick pulses when the counter wraps.
  - Counter runs freely. It resets to 0 on rst and on start-edge detection.
- Start-edge detection: falling edge of the synchronised rx (previous sample 1, current 0). A line held low never re-triggers.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on start edge -> START; tick count = 0.
  - START: at tick count 7 (mid start bit), sample rx.
    - rx = 0 -> DATA; tick count = 0, bit index = 0.
    - rx = 1 -> IDLE (glitch; no output).
  - DATA: at tick count 15, sample rx into shift register LSB-first and reset tick count.
    - After bit index 7 -> STOP.
  - STOP: at tick count 15, sample rx.
    - rx = 1 -> rx_data = shift register, rx_valid = 1, is_control_char updated, tx_paused updated.
    - rx = 0 -> framing_err = 1; rx_data, is_control_char and tx_paused unchanged.
    - Either case -> IDLE.
- Flow control:
  - Good byte 0x13 sets tx_paused.
  - Good byte 0x11 clears tx_paused.
  - Any other byte leaves tx_paused unchanged.
  - Repeated XOFF is idempotent.
- Bytes with bit 7 set are passed through unchanged; no parity.

## Timing
- Reset values:
  - rx_data = 0x00
  - rx_valid = 0
  - is_control_char = 0
  - framing_err = 0
  - tx_paused = 0
  - FSM = IDLE
  - synchroniser = 1
- rst mid-frame: the partial frame is discarded. No output pulse occurs for it. The receiver needs a fresh falling edge after reset.
- Latency: start edge at pin -> rx_valid is 2 sync cycles + (8 + 8·16 + 16)·DIV clocks ±DIV. Sampling lands within ±1 tick of each bit centre.
- rx_valid and framing_err are registered and mutually exclusive. Each is high for exactly 1 clk per frame.
- tx_paused, rx_data and is_control_char change in the same cycle rx_valid is high.
- Back-to-back frames: a start edge arriving during the STOP sample cycle is caught in IDLE on the next cycle. Zero idle bits between frames are supported.
- No ready/backpressure. The consumer must accept rx_valid when it is presented.

## Structure
- Package uart_pkg holds:
  - OSR = 16
  - CTRL_XOFF = 8'h13
  - CTRL_XON = 8'h11
  - typedef enum logic [1:0] uart_rx_state_t {IDLE, START, DATA, STOP}
- The cipher stage should use CTRL_XOFF/CTRL_XON from the same package.
- One sub-module: uart_baud_tick. Parameter DIV; ports clk, rst, clr, tick.
- Synchroniser, FSM, shift register and flow-control flag live in uart_rx_flow.

## Test plan
Use CLK_FREQ = 1_600_000, BAUD = 10_000 (DIV = 10, 160 clk/bit).
- Reset, then send 0x41 -> one rx_valid pulse, rx_data = 0x41, is_control_char = 0, tx_paused = 0, framing_err never high.
- Send 0x13, then 0x61, then 0x11 -> tx_paused rises with the first rx_valid and is_control_char = 1. On 0x61, tx_paused stays 1 and is_control_char = 0. tx_paused falls with the third rx_valid, where is_control_char = 1.
- Frame 0x55 with stop bit driven 0 -> framing_err pulses once, no rx_valid, rx_data keeps its previous value. The next good 0xAA is received correctly after the line returns high.
- Low glitch of 50 clk on idle rx -> no rx_valid, no framing_err, FSM back in IDLE.
- Three back-to-back frames 0x00, 0xFF, 0x7A with zero idle gap -> three rx_valid pulses, correct data in order.
- Assert rst during bit 4 of a frame -> all outputs at reset values, no pulse for the aborted frame. A following 0x5A is received correctly.
